// File: rtl/uart_tx_controller_if.sv
// Host-side bus of the UART transmit controller: write strobe and byte,
// decoder bits 9/10 coming back, and the ready/done handshake.
interface uart_tx_controller_if;
  logic       write;
  logic [7:0] out_port;
  logic       b10;
  logic       b9;
  logic [7:0] load_data;
  logic       tx_rdy;
  logic       tx_done;

  modport master (
    output write, out_port, b10, b9,
    input  load_data, tx_rdy, tx_done
  );

  modport slave (
    input  write, out_port, b10, b9,
    output load_data, tx_rdy, tx_done
  );
endinterface

// File: rtl/uart_tx_controller.sv
// UART transmit sequencer: captures a host byte, builds an 11-bit frame with
// decoder-supplied bits 9/10, and shifts it out LSB-first at baud_k clocks per bit.
module uart_tx_controller #(
  parameter int unsigned BAUD_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BAUD_W-1:0] baud_k,
  output logic              tx,
  uart_tx_controller_if.slave bus
);

  localparam int unsigned FRAME_W = 11;
  localparam int unsigned BITCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t              state;
  logic [FRAME_W-1:0]  shift_reg;
  logic [BITCNT_W-1:0] bit_cnt;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [BAUD_W-1:0]   reload;
  logic [BAUD_W-1:0]   reload_c;

  // A divisor of 0 behaves like 1: reload value is max(baud_k,1)-1.
  assign reload_c = (baud_k == '0) ? '0 : baud_k - BAUD_W'(1);

  // tx is the shift register's LSB; the register idles at all ones.
  assign tx = shift_reg[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      shift_reg     <= 11'h7FF;
      bit_cnt       <= '0;
      baud_cnt      <= '0;
      reload        <= '0;
      bus.load_data <= 8'h00;
      bus.tx_rdy    <= 1'b1;
      bus.tx_done   <= 1'b0;
    end else begin
      bus.tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.write) begin
            bus.load_data <= bus.out_port;
            bus.tx_rdy    <= 1'b0;
            state         <= LATCH;
          end
        end
        LATCH: begin
          shift_reg <= {bus.b10, bus.b9, bus.load_data[6:0], 1'b0, 1'b1};
          baud_cnt  <= reload_c;
          reload    <= reload_c;
          bit_cnt   <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (baud_cnt == '0) begin
            shift_reg <= {1'b1, shift_reg[FRAME_W-1:1]};
            baud_cnt  <= reload;
            // Eleventh period boundary: the b10 bit has been on tx for a full period.
            if (bit_cnt == BITCNT_W'(10)) begin
              bit_cnt     <= '0;
              bus.tx_rdy  <= 1'b1;
              bus.tx_done <= 1'b1;
              state       <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + BITCNT_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed bench for uart_tx_controller: table of frames with hand-computed
// bit patterns, plus hand-written reset-abort and back-to-back sequences.
module tb_uart_tx_controller;

  localparam int unsigned BAUD_W = 19;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [BAUD_W-1:0] baud_k = '0;
  logic              tx;

  int checks = 0;
  int errors = 0;

  uart_tx_controller_if bus ();

  uart_tx_controller #(.BAUD_W(BAUD_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .baud_k (baud_k),
    .tx     (tx),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BAUD_W-1:0] baud_k;
    int                k_eff;
    logic [7:0]        data;
    logic              b10;
    logic              b9;
    logic [10:0]       frame;   // bit0 is sent first
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Called at #1 after an edge while tx_rdy=1; on return the bench sits in the
  // tx_rdy-rise cycle, so calling again immediately exercises back-to-back writes.
  task automatic run_frame(input vec_t v, input int inject_at);
    int k;
    k = v.k_eff;
    baud_k       = v.baud_k;
    bus.b10      = v.b10;
    bus.b9       = v.b9;
    bus.out_port = v.data;
    bus.write    = 1'b1;
    @(posedge clk); #1;
    bus.write = 1'b0;
    chk("latch_load_data", 32'(bus.load_data), 32'(v.data));
    chk("latch_tx_rdy", 32'(bus.tx_rdy), 32'(0));
    chk("latch_tx", 32'(tx), 32'(1));
    for (int i = 0; i <= 11 * k; i++) begin
      @(posedge clk); #1;
      if (i == 0) baud_k = 19'd7;
      if (i == inject_at + 1) begin
        bus.write    = 1'b0;
        bus.out_port = v.data;
      end
      if (i < 11 * k) begin
        chk("frame_bit", 32'(tx), 32'(v.frame[i / k]));
        chk("busy_tx_rdy", 32'(bus.tx_rdy), 32'(0));
        chk("busy_tx_done", 32'(bus.tx_done), 32'(0));
      end else begin
        chk("end_tx_rdy", 32'(bus.tx_rdy), 32'(1));
        chk("end_tx_done", 32'(bus.tx_done), 32'(1));
        chk("end_tx_idle", 32'(tx), 32'(1));
        chk("end_load_data_held", 32'(bus.load_data), 32'(v.data));
      end
      if (i == inject_at) begin
        bus.write    = 1'b1;
        bus.out_port = 8'hA3;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_tx", 32'(tx), 32'(1));
      chk("idle_tx_rdy", 32'(bus.tx_rdy), 32'(1));
      chk("idle_tx_done", 32'(bus.tx_done), 32'(0));
    end
  endtask

  initial begin
    bus.write    = 1'b0;
    bus.out_port = 8'h00;
    bus.b10      = 1'b0;
    bus.b9       = 1'b0;

    vecs[0] = '{baud_k: 19'd4, k_eff: 4, data: 8'h55, b10: 1'b1, b9: 1'b0, frame: 11'h555};
    vecs[1] = '{baud_k: 19'd0, k_eff: 1, data: 8'h01, b10: 1'b0, b9: 1'b1, frame: 11'h205};
    vecs[2] = '{baud_k: 19'd2, k_eff: 2, data: 8'hC3, b10: 1'b1, b9: 1'b1, frame: 11'h70D};
    vecs[3] = '{baud_k: 19'd3, k_eff: 3, data: 8'h80, b10: 1'b0, b9: 1'b0, frame: 11'h001};
    vecs[4] = '{baud_k: 19'd8, k_eff: 8, data: 8'h3C, b10: 1'b0, b9: 1'b1, frame: 11'h2F1};

    // Reset held three clocks.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", 32'(tx), 32'(1));
    chk("reset_tx_rdy", 32'(bus.tx_rdy), 32'(1));
    chk("reset_tx_done", 32'(bus.tx_done), 32'(0));
    chk("reset_load_data", 32'(bus.load_data), 32'(8'h00));
    reset = 1'b0;
    idle_cycles(2);

    // Table: vector 0 carries an ignored mid-frame write; 1->2->3 run back-to-back.
    for (int n = 0; n < 4; n++) begin
      run_frame(vecs[n], (n == 0) ? 10 : -1);
      if (n == 0) idle_cycles(3);
    end
    idle_cycles(2);

    // Reset in the middle of bit 5 of a K=8 frame.
    baud_k       = vecs[4].baud_k;
    bus.b10      = vecs[4].b10;
    bus.b9       = vecs[4].b9;
    bus.out_port = vecs[4].data;
    bus.write    = 1'b1;
    @(posedge clk); #1;
    bus.write = 1'b0;
    repeat (1 + 5 * 8 + 3) @(posedge clk);
    #1;
    chk("pre_abort_tx_bit5", 32'(tx), 32'(vecs[4].frame[5]));
    chk("pre_abort_tx_rdy", 32'(bus.tx_rdy), 32'(0));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_tx", 32'(tx), 32'(1));
    chk("abort_tx_rdy", 32'(bus.tx_rdy), 32'(1));
    chk("abort_tx_done", 32'(bus.tx_done), 32'(0));
    chk("abort_load_data", 32'(bus.load_data), 32'(8'h00));
    reset = 1'b0;
    idle_cycles(2);
    run_frame(vecs[4], -1);
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
